// File: rtl/exec_unit_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: iterative shift-add multiplier and
// restoring divider sharing one accumulator, sequenced by an IDLE/CALC/FIX/DONE FSM.
module exec_unit_muldiv #(
    parameter int DATA_WIDTH  = 32,
    parameter int MD_OP_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [MD_OP_WIDTH-1:0] md_op_i,
    input  logic [DATA_WIDTH-1:0]  rs1_i,
    input  logic [DATA_WIDTH-1:0]  rs2_i,
    input  logic                   kill_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  result_o
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [MD_OP_WIDTH-1:0] OP_MUL    = MD_OP_WIDTH'(0);
    localparam logic [MD_OP_WIDTH-1:0] OP_MULH   = MD_OP_WIDTH'(1);
    localparam logic [MD_OP_WIDTH-1:0] OP_MULHSU = MD_OP_WIDTH'(2);
    localparam logic [MD_OP_WIDTH-1:0] OP_MULHU  = MD_OP_WIDTH'(3);
    localparam logic [MD_OP_WIDTH-1:0] OP_DIV    = MD_OP_WIDTH'(4);
    localparam logic [MD_OP_WIDTH-1:0] OP_DIVU   = MD_OP_WIDTH'(5);
    localparam logic [MD_OP_WIDTH-1:0] OP_REM    = MD_OP_WIDTH'(6);
    localparam logic [MD_OP_WIDTH-1:0] OP_REMU   = MD_OP_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state, state_next;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [MD_OP_WIDTH-1:0]    op_q;
    logic                      sgn1, sgn2;
    logic [DATA_WIDTH-1:0]     opnd;
    logic [2*DATA_WIDTH-1:0]   acc;
    logic                      busy_q, done_q;
    logic [DATA_WIDTH-1:0]     result_q;

    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? ({DATA_WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*DATA_WIDTH-1:0] cond_neg2(input logic [2*DATA_WIDTH-1:0] v,
                                                          input logic neg);
        return neg ? ({(2*DATA_WIDTH){1'b0}} - v) : v;
    endfunction

    // Accept-time decode of the incoming request
    logic                  accept, is_div_in, is_rem_in, signed_div_in;
    logic                  sgn1_in, sgn2_in, div_zero, div_ovf, special;
    logic [DATA_WIDTH-1:0] mag1_in, mag2_in, special_val;

    always_comb begin
        accept        = (state == IDLE) && start_i && !kill_i;
        is_div_in     = (md_op_i >= OP_DIV);
        is_rem_in     = (md_op_i == OP_REM) || (md_op_i == OP_REMU);
        signed_div_in = (md_op_i == OP_DIV) || (md_op_i == OP_REM);
        sgn1_in       = ((md_op_i == OP_MULH) || (md_op_i == OP_MULHSU) || signed_div_in)
                        && rs1_i[DATA_WIDTH-1];
        sgn2_in       = ((md_op_i == OP_MULH) || signed_div_in) && rs2_i[DATA_WIDTH-1];
        mag1_in       = cond_neg(rs1_i, sgn1_in);
        mag2_in       = cond_neg(rs2_i, sgn2_in);
        div_zero      = (rs2_i == {DATA_WIDTH{1'b0}});
        div_ovf       = signed_div_in && (rs1_i == MOST_NEG) && (rs2_i == {DATA_WIDTH{1'b1}});
        special       = is_div_in && (div_zero || div_ovf);
        if (div_zero) begin
            special_val = is_rem_in ? rs1_i : {DATA_WIDTH{1'b1}};
        end else begin
            special_val = is_rem_in ? {DATA_WIDTH{1'b0}} : MOST_NEG;
        end
    end

    // One iteration of either algorithm on the shared accumulator
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH+1:0]   div_trial;
    logic                    div_borrow;
    logic [2*DATA_WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum    = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + {1'b0, (acc[0] ? opnd : {DATA_WIDTH{1'b0}})};
        mul_next   = {mul_sum, acc[DATA_WIDTH-1:1]};
        div_trial  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH-1]} - {2'b00, opnd};
        div_borrow = div_trial[DATA_WIDTH+1];
        div_next   = {(div_borrow ? acc[2*DATA_WIDTH-2:DATA_WIDTH-1] : div_trial[DATA_WIDTH-1:0]),
                      acc[DATA_WIDTH-2:0], ~div_borrow};
    end

    // Sign fix-up and result selection
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quot_fix, rem_fix, fix_val;

    always_comb begin
        prod_fix = cond_neg2(acc, sgn1 ^ sgn2);
        quot_fix = cond_neg(acc[DATA_WIDTH-1:0], sgn1 ^ sgn2);
        rem_fix  = cond_neg(acc[2*DATA_WIDTH-1:DATA_WIDTH], sgn1);
        case (op_q)
            OP_MUL:                        fix_val = prod_fix[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:               fix_val = quot_fix;
            default:                       fix_val = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill_i) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt      <= '0;
            op_q     <= '0;
            sgn1     <= 1'b0;
            sgn2     <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == DONE);
            if (accept) begin
                op_q <= md_op_i;
                sgn1 <= sgn1_in;
                sgn2 <= sgn2_in;
                cnt  <= CNT_INIT;
                // Multiplier / dividend enters the low half; the other operand is held aside
                opnd <= is_div_in ? mag2_in : mag1_in;
                acc  <= {{DATA_WIDTH{1'b0}}, (is_div_in ? mag1_in : mag2_in)};
                if (special) result_q <= special_val;
            end else if (state == CALC && !kill_i) begin
                acc <= (op_q >= OP_DIV) ? div_next : mul_next;
                cnt <= cnt - CNT_LAST;
            end else if (state == FIX && !kill_i) begin
                result_q <= fix_val;
            end
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule
